// File: rtl/t08_mem_pkg.sv
// t08_mem_pkg -- shared types and helpers for the t08 memory handler.
//   state_e          : handler FSM states (IDLE, BUSY, DONE)
//   F3_*             : funct3 access-size encodings
//   access_legal()   : alignment / encoding / request legality check
//   lane_sel()       : byte-lane enables for a size and byte offset
package t08_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic access_legal(input logic       rd,
                                        input logic       wr,
                                        input logic [2:0] f3,
                                        input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_BU: ok = 1'b1;
      F3_H, F3_HU: ok = ~off[0];
      F3_W:        ok = (off == 2'b00);
      default:     ok = 1'b0;
    endcase
    // Unsigned variants exist only for loads.
    if (wr && f3[2]) ok = 1'b0;
    if (rd && wr)    ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [3:0] lane_sel(input logic [2:0] f3,
                                          input logic [1:0] off);
    logic [3:0] s;
    case (f3[1:0])
      2'b00:   s = 4'b0001 << off;
      2'b01:   s = 4'b0011 << off;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/t08_memory_handler_if.sv
// t08_memory_handler_if -- data-bus signals between the memory handler
// (master) and the data-bus manager (slave).
//   bus_addr  32  word-aligned address         (master -> slave)
//   bus_wdata 32  lane-replicated store data   (master -> slave)
//   bus_sel    4  byte-lane enables            (master -> slave)
//   bus_re     1  read request                 (master -> slave)
//   bus_we     1  write request                (master -> slave)
//   bus_rdata 32  read data                    (slave -> master)
//   bus_ack    1  one-cycle transfer complete  (slave -> master)
interface t08_memory_handler_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic        bus_re;
  logic        bus_we;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_addr, bus_wdata, bus_sel, bus_re, bus_we,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_sel, bus_re, bus_we,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/t08_load_extend.sv
// t08_load_extend -- combinational load alignment and extension.
//   rdata_i  32  raw bus word
//   offset_i  2  byte offset within the word
//   funct3_i  3  access size / signedness
//   data_o   32  selected byte/half, sign- or zero-extended (word passes through)
module t08_load_extend
  import t08_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata_i[7:0];
    case (offset_i)
      2'd0: byte_v = rdata_i[7:0];
      2'd1: byte_v = rdata_i[15:8];
      2'd2: byte_v = rdata_i[23:16];
      2'd3: byte_v = rdata_i[31:24];
      default: byte_v = rdata_i[7:0];
    endcase
    half_v = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      F3_B:    data_o = {{24{byte_v[7]}}, byte_v};
      F3_BU:   data_o = {24'h0, byte_v};
      F3_H:    data_o = {{16{half_v[15]}}, half_v};
      F3_HU:   data_o = {16'h0, half_v};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/t08_memory_handler.sv
// t08_memory_handler -- executes RV32I loads/stores on the data bus and
// stalls the core until the access completes.
//   clk, rst     clock, synchronous active-high reset
//   read, write  load / store request from the control unit
//   funct3       access size (B, H, W, BU, HU)
//   address      byte address from the ALU
//   store_data   rs2 value for stores
//   load_data    extended load result, held until the next load completes
//   freeze       stall PC / register writes
//   mem_err      one-cycle pulse on illegal access or bus timeout
//   bus          data-bus master port (t08_memory_handler_if.master)
// Optional bus timeout: define T08_MEM_TIMEOUT_EN (parameter TIMEOUT_CYCLES).
module t08_memory_handler
  import t08_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
)
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        read,
  input  logic                        write,
  input  logic [2:0]                  funct3,
  input  logic [31:0]                 address,
  input  logic [31:0]                 store_data,
  output logic [31:0]                 load_data,
  output logic                        freeze,
  output logic                        mem_err,
  t08_memory_handler_if.master        bus
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, load_q;
  logic [3:0]  sel_q;
  logic        re_q, we_q, err_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [31:0] ext_data;
  logic [31:0] wdata_rep;
  logic        start, legal, timeout_hit;

  assign start = read | write;
  assign legal = access_legal(read, write, funct3, address[1:0]);

  t08_load_extend u_ext (
    .rdata_i  (bus.bus_rdata),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .data_o   (ext_data)
  );

  always_comb begin
    case (funct3[1:0])
      2'b00:   wdata_rep = {4{store_data[7:0]}};
      2'b01:   wdata_rep = {2{store_data[15:0]}};
      default: wdata_rep = store_data;
    endcase
  end

`ifdef T08_MEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt_q;

  // Held at zero outside BUSY, so it is already clear on BUSY entry.
  always_ff @(posedge clk) begin
    if (rst || state_q != BUSY) cnt_q <= '0;
    else                        cnt_q <= cnt_q + 1'b1;
  end

  always_comb begin
    timeout_hit = (state_q == BUSY) && !bus.bus_ack &&
                  (32'(cnt_q) == TIMEOUT_CYCLES - 32'd1);
  end
`else
  always_comb timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = legal ? BUSY : DONE;
      BUSY: if (bus.bus_ack || timeout_hit) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    freeze = ((state_q == IDLE) && start) || (state_q == BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      off_q   <= '0;
      f3_q    <= '0;
      load_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (legal) begin
              addr_q  <= {address[31:2], 2'b00};
              wdata_q <= wdata_rep;
              sel_q   <= lane_sel(funct3, address[1:0]);
              re_q    <= read;
              we_q    <= write;
              off_q   <= address[1:0];
              f3_q    <= funct3;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (bus.bus_ack) begin
            re_q <= 1'b0;
            we_q <= 1'b0;
            if (re_q) load_q <= ext_data;
          end else if (timeout_hit) begin
            re_q  <= 1'b0;
            we_q  <= 1'b0;
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_sel   = sel_q;
  assign bus.bus_re    = re_q;
  assign bus.bus_we    = we_q;
  assign load_data     = load_q;
  assign mem_err       = err_q;

endmodule

// File: tb/tb_t08_memory_handler.sv
// tb_t08_memory_handler -- directed self-checking bench for t08_memory_handler.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_t08_memory_handler;
  import t08_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        read, write;
  logic [2:0]  funct3;
  logic [31:0] address, store_data, load_data;
  logic        freeze, mem_err;

  int n_vec = 0;
  int n_bad = 0;

  t08_memory_handler_if bus ();

  t08_memory_handler #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .read       (read),
    .write      (write),
    .funct3     (funct3),
    .address    (address),
    .store_data (store_data),
    .load_data  (load_data),
    .freeze     (freeze),
    .mem_err    (mem_err),
    .bus        (bus)
  );

  logic [31:0] x_rdata, x_out;
  logic [1:0]  x_off;
  logic [2:0]  x_f3;

  t08_load_extend u_ref (
    .rdata_i  (x_rdata),
    .offset_i (x_off),
    .funct3_i (x_f3),
    .data_o   (x_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          r_re, r_we, r_fr, r_err;
  logic [31:0] r_ld, r_sel, r_wdata, r_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sd,
                            input int waits, input logic [31:0] rv);
    int   busy;
    logic done;
    read = rd; write = wr; funct3 = f3; address = addr; store_data = sd;
    r_re = 0; r_we = 0; r_fr = 0; r_err = 0;
    r_ld = '0; r_sel = '0; r_wdata = '0; r_addr = '0;
    busy = 0; done = 1'b0;
    #1;
    for (int c = 0; c < 64 && !done; c++) begin
      if (freeze)     r_fr++;
      if (bus.bus_re) r_re++;
      if (bus.bus_we) r_we++;
      if (mem_err)    r_err++;
      if (bus.bus_re || bus.bus_we) begin
        busy++;
        r_sel   = 32'(bus.bus_sel);
        r_wdata = bus.bus_wdata;
        r_addr  = bus.bus_addr;
        bus.bus_ack   = (busy == waits + 1);
        bus.bus_rdata = (busy == waits + 1) ? rv : 32'h0;
      end else begin
        bus.bus_ack   = 1'b0;
        bus.bus_rdata = 32'h0;
      end
      if (!freeze) begin
        done  = 1'b1;
        read  = 1'b0;
        write = 1'b0;
        r_ld  = load_data;
      end else begin
        @(negedge clk);
      end
    end
    chk("access_done", 32'(done), 32'd1);
    bus.bus_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; read = 1'b0; write = 1'b0; funct3 = '0; address = '0; store_data = '0;
    bus.bus_ack = 1'b0; bus.bus_rdata = '0;
    x_rdata = '0; x_off = '0; x_f3 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_load_data", load_data, 32'h0);
    chk("rst_bus_addr",  bus.bus_addr, 32'h0);
    chk("rst_bus_wdata", bus.bus_wdata, 32'h0);
    chk("rst_bus_sel",   32'(bus.bus_sel), 32'h0);
    chk("rst_re_we_err", {29'h0, bus.bus_re, bus.bus_we, mem_err}, 32'h0);
    chk("rst_freeze",    32'(freeze), 32'h0);

    run_access(1'b1, 1'b0, F3_W, 32'h0000_0100, 32'h0, 2, 32'hDEAD_BEEF);
    chk("lw_re_cycles", 32'(r_re), 32'd3);
    chk("lw_freeze",    32'(r_fr), 32'd4);
    chk("lw_sel",       r_sel, 32'hF);
    chk("lw_addr",      r_addr, 32'h0000_0100);
    chk("lw_data",      r_ld, 32'hDEAD_BEEF);
    chk("lw_err",       32'(r_err), 32'd0);
    chk("lw_hold",      load_data, 32'hDEAD_BEEF);

    run_access(1'b1, 1'b0, F3_B, 32'h0000_0203, 32'h0, 0, 32'h80FF_FFFF);
    chk("lb_sel",    r_sel, 32'h8);
    chk("lb_addr",   r_addr, 32'h0000_0200);
    chk("lb_data",   r_ld, 32'hFFFF_FF80);
    chk("lb_freeze", 32'(r_fr), 32'd2);
    run_access(1'b1, 1'b0, F3_BU, 32'h0000_0203, 32'h0, 0, 32'h80FF_FFFF);
    chk("lbu_data",  r_ld, 32'h0000_0080);

    run_access(1'b0, 1'b1, F3_H, 32'h0000_0302, 32'h1234_ABCD, 1, 32'h0);
    chk("sh_we",     32'(r_we), 32'd2);
    chk("sh_re",     32'(r_re), 32'd0);
    chk("sh_sel",    r_sel, 32'hC);
    chk("sh_wdata",  r_wdata, 32'hABCD_ABCD);
    chk("sh_addr",   r_addr, 32'h0000_0300);
    chk("sh_ld_keep", r_ld, 32'h0000_0080);

    run_access(1'b0, 1'b1, F3_B, 32'h0000_0101, 32'h0000_00A5, 0, 32'h0);
    chk("sb_sel",   r_sel, 32'h2);
    chk("sb_wdata", r_wdata, 32'hA5A5_A5A5);
    run_access(1'b0, 1'b1, F3_W, 32'h0000_0104, 32'hCAFE_F00D, 0, 32'h0);
    chk("sw_sel",   r_sel, 32'hF);
    chk("sw_wdata", r_wdata, 32'hCAFE_F00D);
    chk("sw_addr",  r_addr, 32'h0000_0104);

    run_access(1'b1, 1'b0, F3_H, 32'h0000_0102, 32'h0, 0, 32'h8001_7FFF);
    chk("lh_sel",   r_sel, 32'hC);
    chk("lh_data",  r_ld, 32'hFFFF_8001);
    run_access(1'b1, 1'b0, F3_HU, 32'h0000_0102, 32'h0, 0, 32'h8001_7FFF);
    chk("lhu_data", r_ld, 32'h0000_8001);
    run_access(1'b1, 1'b0, F3_B, 32'h0000_0100, 32'h0, 0, 32'hFFFF_FF7F);
    chk("lb0_sel",  r_sel, 32'h1);
    chk("lb0_data", r_ld, 32'h0000_007F);

    run_access(1'b1, 1'b0, F3_W, 32'h0000_0101, 32'h0, 0, 32'h0);
    chk("lw_mis_re",   32'(r_re), 32'd0);
    chk("lw_mis_err",  32'(r_err), 32'd1);
    chk("lw_mis_fr",   32'(r_fr), 32'd1);
    chk("lw_mis_ld",   r_ld, 32'h0000_007F);
    chk("err_cleared", 32'(mem_err), 32'd0);
    run_access(1'b1, 1'b0, F3_H, 32'h0000_0103, 32'h0, 0, 32'h0);
    chk("lh_mis_re",   32'(r_re), 32'd0);
    chk("lh_mis_err",  32'(r_err), 32'd1);
    chk("lh_mis_fr",   32'(r_fr), 32'd1);
    run_access(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 0, 32'h0);
    chk("f3_011_err",  32'(r_err), 32'd1);
    run_access(1'b0, 1'b1, F3_BU, 32'h0000_0100, 32'h0, 0, 32'h0);
    chk("sbu_we",      32'(r_we), 32'd0);
    chk("sbu_err",     32'(r_err), 32'd1);
    run_access(1'b1, 1'b1, F3_W, 32'h0000_0100, 32'h0, 0, 32'h0);
    chk("rw_both_req", 32'(r_re + r_we), 32'd0);
    chk("rw_both_err", 32'(r_err), 32'd1);
    chk("ill_ld_keep", load_data, 32'h0000_007F);

    read = 1'b1; funct3 = F3_W; address = 32'h0000_0200;
    @(negedge clk);
    chk("rb_busy_re", 32'(bus.bus_re), 32'd1);
    rst = 1'b1; read = 1'b0;
    @(negedge clk);
    chk("rb_re",     32'(bus.bus_re), 32'd0);
    chk("rb_sel",    32'(bus.bus_sel), 32'h0);
    chk("rb_addr",   bus.bus_addr, 32'h0);
    chk("rb_ld",     load_data, 32'h0);
    chk("rb_freeze", 32'(freeze), 32'd0);
    rst = 1'b0; bus.bus_ack = 1'b1; bus.bus_rdata = 32'h1234_5678;
    @(negedge clk);
    bus.bus_ack = 1'b0; bus.bus_rdata = 32'h0;
    chk("late_ack_ld",  load_data, 32'h0);
    chk("late_ack_fr",  32'(freeze), 32'd0);
    chk("late_ack_err", 32'(mem_err), 32'd0);
    @(negedge clk);
    chk("late_ack_idle", 32'(freeze), 32'd0);

`ifdef T08_MEM_TIMEOUT_EN
    run_access(1'b1, 1'b0, F3_W, 32'h0000_0400, 32'h0, 1000, 32'h0);
    chk("to_re",     32'(r_re), 32'd4);
    chk("to_freeze", 32'(r_fr), 32'd5);
    chk("to_err",    32'(r_err), 32'd1);
    chk("to_ld",     r_ld, 32'h0);
    chk("to_req_off", 32'(bus.bus_re), 32'd0);
`endif

    x_rdata = 32'h1234_5678; x_off = 2'd1; x_f3 = F3_B; #1;
    chk("ext_b1",  x_out, 32'h0000_0056);
    x_rdata = 32'h9ABC_DEF0; x_off = 2'd2; x_f3 = F3_H; #1;
    chk("ext_h2",  x_out, 32'hFFFF_9ABC);
    x_off = 2'd3; x_f3 = F3_BU; #1;
    chk("ext_bu3", x_out, 32'h0000_009A);
    x_off = 2'd0; x_f3 = F3_HU; #1;
    chk("ext_hu0", x_out, 32'h0000_DEF0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
